// File: rtl/wb_cmd_master.sv
// Wishbone B3 classic single-cycle master fed by a small command FIFO.
// Each command produces one bus cycle, with rty retries and a timeout,
// and returns one status response.
module wb_cmd_master #(
  parameter int unsigned AW        = 3,
  parameter int unsigned DW        = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3,
  localparam int unsigned SW       = DW / 8,
  localparam int unsigned RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          wb_clk_i,
  input  logic          arst_ni,
  // command port
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [DW-1:0] cmd_dat_i,
  input  logic [SW-1:0] cmd_sel_i,
  // response port
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_dat_o,
  output logic [1:0]    rsp_sts_o,
  output logic [RW-1:0] rsp_retries_o,
  // wishbone master
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [SW-1:0] wb_sel_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  output logic          busy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned FW = 1 + AW + DW + SW;

  localparam logic [1:0] STS_OK   = 2'b00;
  localparam logic [1:0] STS_ERR  = 2'b01;
  localparam logic [1:0] STS_RTY  = 2'b10;
  localparam logic [1:0] STS_TMO  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_BACKOFF, S_RESP} state_e;

  logic [1:0]    rst_sync_q;
  logic          rst_n;
  logic [FW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          rsp_valid_d;
  logic [DW-1:0] rsp_dat_d;
  logic [1:0]    rsp_sts_d;
  logic [RW-1:0] rsp_retries_d;

  assign push    = cmd_valid_i & cmd_ready_o;
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign rst_n   = rst_sync_q[1];

  // Reset synchronizer: assertion is immediate, release is aligned to the clock.
  always_ff @(posedge wb_clk_i or negedge arst_ni) begin
    if (!arst_ni) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // Command storage; contents need no reset since count gates every read.
  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i};
  end

  // Next-state and next-output logic for the bus sequencer.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    tmo_d         = tmo_q;
    retry_d       = retry_q;
    rsp_valid_d   = rsp_valid_o;
    rsp_dat_d     = rsp_dat_o;
    rsp_sts_d     = rsp_sts_o;
    rsp_retries_d = rsp_retries_o;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_BUS;
          tmo_d   = '0;
          retry_d = '0;
        end
      end
      S_BUS: begin
        if (wb_err_i) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_sts_d     = STS_ERR;
          rsp_dat_d     = '0;
          rsp_retries_d = retry_q;
        end else if (wb_ack_i) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_sts_d     = STS_OK;
          rsp_dat_d     = wb_we_o ? '0 : wb_dat_i;
          rsp_retries_d = retry_q;
        end else if (wb_rty_i) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            state_d = S_BACKOFF;
            retry_d = retry_q + RW'(1);
          end else begin
            state_d       = S_RESP;
            rsp_valid_d   = 1'b1;
            rsp_sts_d     = STS_RTY;
            rsp_dat_d     = '0;
            rsp_retries_d = retry_q;
          end
        end else if (tmo_q == TW'(TIMEOUT)) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_sts_d     = STS_TMO;
          rsp_dat_d     = '0;
          rsp_retries_d = retry_q;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_BACKOFF: begin
        state_d = S_BUS;
        tmo_d   = '0;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_BUS;
            tmo_d   = '0;
            retry_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, FIFO bookkeeping and registered outputs.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tmo_q         <= '0;
      retry_q       <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cmd_ready_o   <= 1'b0;
      busy_o        <= 1'b0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_sel_o      <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_dat_o     <= '0;
      rsp_sts_o     <= '0;
      rsp_retries_o <= '0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      retry_q       <= retry_d;
      count_q       <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cmd_ready_o   <= (count_d != CW'(DEPTH));
      busy_o        <= (count_d != '0) || (state_d != S_IDLE);
      wb_cyc_o      <= (state_d == S_BUS);
      wb_stb_o      <= (state_d == S_BUS);
      if (pop) {wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} <= fifo_mem[rd_ptr_q];
      rsp_valid_o   <= rsp_valid_d;
      rsp_dat_o     <= rsp_dat_d;
      rsp_sts_o     <= rsp_sts_d;
      rsp_retries_o <= rsp_retries_d;
    end
  end

endmodule
